// File: rtl/edge_seq_driver.sv
// Timed pin-change sequencer for one edge-reactive responder: a command FIFO feeds
// an IDLE/WAIT/APPLY engine, and a synchronised monitor reports responder edges.
module edge_seq_driver #(
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_sel,
  input  logic          cmd_level,
  input  logic [DW-1:0] cmd_delay,
  output logic          drv_a,
  output logic          drv_module_a,
  input  logic          rsp_b,
  input  logic          rsp_module_b,
  output logic          busy,
  output logic          evt_valid,
  output logic [1:0]    evt_code,
  output logic [CW-1:0] evt_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 3 + DW;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_APPLY} state_t;

  state_t        state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [DW-1:0] cnt_q, cnt_d;
  logic [1:0]    cur_sel_q, cur_sel_d;
  logic          cur_level_q, cur_level_d;
  logic          drv_a_q, drv_a_d, drv_module_a_q, drv_module_a_d;
  logic          full, empty, push, pop;
  logic [EW-1:0] head;

  logic [1:0]    sync_b_q, sync_b_d, sync_mb_q, sync_mb_d;
  logic          prev_b_q, prev_b_d, prev_mb_q, prev_mb_d;
  logic          pend_q, pend_d, pend_dir_q, pend_dir_d;
  logic          evt_valid_q, evt_valid_d;
  logic [1:0]    evt_code_q, evt_code_d;
  logic [CW-1:0] evt_count_q, evt_count_d;
  logic          b_edge, mb_edge;

  // Full when the index bits match but the wrap bits differ.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = cmd_valid && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_sel, cmd_level, cmd_delay};
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cur_sel_d      = cur_sel_q;
    cur_level_d    = cur_level_q;
    drv_a_d        = drv_a_q;
    drv_module_a_d = drv_module_a_q;
    pop            = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop         = 1'b1;
          cur_sel_d   = head[EW-1 -: 2];
          cur_level_d = head[DW];
          cnt_d       = head[DW-1:0];
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_APPLY;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_APPLY: begin
        case (cur_sel_q)
          2'b00:   drv_a_d        = cur_level_q;
          2'b01:   drv_module_a_d = cur_level_q;
          2'b10: begin
            drv_a_d        = cur_level_q;
            drv_module_a_d = cur_level_q;
          end
          default: ;
        endcase
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  assign b_edge  = sync_b_q[1] ^ prev_b_q;
  assign mb_edge = sync_mb_q[1] ^ prev_mb_q;

  // A b edge always wins the slot; a coincident module_b edge waits one cycle in pend.
  always_comb begin
    sync_b_d    = {sync_b_q[0], rsp_b};
    sync_mb_d   = {sync_mb_q[0], rsp_module_b};
    prev_b_d    = sync_b_q[1];
    prev_mb_d   = sync_mb_q[1];
    pend_d      = pend_q;
    pend_dir_d  = pend_dir_q;
    evt_valid_d = 1'b0;
    evt_code_d  = evt_code_q;
    if (b_edge) begin
      evt_valid_d = 1'b1;
      evt_code_d  = {1'b0, sync_b_q[1]};
      if (mb_edge) begin
        pend_d     = 1'b1;
        pend_dir_d = sync_mb_q[1];
      end
    end else if (pend_q) begin
      evt_valid_d = 1'b1;
      evt_code_d  = {1'b1, pend_dir_q};
      pend_d      = mb_edge;
      if (mb_edge) pend_dir_d = sync_mb_q[1];
    end else if (mb_edge) begin
      evt_valid_d = 1'b1;
      evt_code_d  = {1'b1, sync_mb_q[1]};
    end
    evt_count_d = evt_count_q + {{(CW-1){1'b0}}, evt_valid_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      cur_sel_q      <= 2'b11;
      cur_level_q    <= 1'b0;
      drv_a_q        <= 1'b0;
      drv_module_a_q <= 1'b0;
      sync_b_q       <= '0;
      sync_mb_q      <= '0;
      prev_b_q       <= 1'b0;
      prev_mb_q      <= 1'b0;
      pend_q         <= 1'b0;
      pend_dir_q     <= 1'b0;
      evt_valid_q    <= 1'b0;
      evt_code_q     <= '0;
      evt_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
      cur_sel_q      <= cur_sel_d;
      cur_level_q    <= cur_level_d;
      drv_a_q        <= drv_a_d;
      drv_module_a_q <= drv_module_a_d;
      sync_b_q       <= sync_b_d;
      sync_mb_q      <= sync_mb_d;
      prev_b_q       <= prev_b_d;
      prev_mb_q      <= prev_mb_d;
      pend_q         <= pend_d;
      pend_dir_q     <= pend_dir_d;
      evt_valid_q    <= evt_valid_d;
      evt_code_q     <= evt_code_d;
      evt_count_q    <= evt_count_d;
    end
  end

  assign cmd_ready    = !full;
  assign busy         = !empty || (state_q != S_IDLE);
  assign drv_a        = drv_a_q;
  assign drv_module_a = drv_module_a_q;
  assign evt_valid    = evt_valid_q;
  assign evt_code     = evt_code_q;
  assign evt_count    = evt_count_q;

endmodule

// File: tb/tb_edge_seq_driver.sv
// Directed bench for edge_seq_driver: command timing, FIFO backpressure,
// responder loopback events, coincident edges, mid-command reset and counter wrap.
module tb_edge_seq_driver;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_sel;
  logic       cmd_level;
  logic [7:0] cmd_delay;
  logic       drv_a, drv_module_a;
  logic       rsp_b, rsp_module_b;
  logic       busy, evt_valid;
  logic [1:0] evt_code;
  logic [7:0] evt_count;

  logic       loop_en, rsp_b_tb, rsp_mb_tb;
  assign rsp_b        = loop_en ? drv_a        : rsp_b_tb;
  assign rsp_module_b = loop_en ? drv_module_a : rsp_mb_tb;

  edge_seq_driver #(.DEPTH(4), .DW(8), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_level(cmd_level), .cmd_delay(cmd_delay),
    .drv_a(drv_a), .drv_module_a(drv_module_a),
    .rsp_b(rsp_b), .rsp_module_b(rsp_module_b),
    .busy(busy), .evt_valid(evt_valid), .evt_code(evt_code), .evt_count(evt_count)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          acc_cyc = -1;
  logic        acc_flag;
  logic [10:0] cq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic load_cmd();
    if (cq.size() > 0) begin
      cmd_valid = 1'b1;
      {cmd_sel, cmd_level, cmd_delay} = cq[0];
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  // One clock: note acceptance, advance to 1 time unit after the edge, refresh the offer.
  task automatic step();
    logic acc;
    acc = cmd_valid && cmd_ready;
    @(posedge clk);
    #1;
    cyc++;
    acc_flag = acc;
    if (acc) begin
      void'(cq.pop_front());
      acc_cyc = cyc;
    end
    load_cmd();
  endtask

  initial begin
    logic       lv[6];
    int         n0, tt, nacc, acc6, base;
    logic       pa, pma, any_drv;
    logic [1:0] eq_code[$];
    int         eq_time[$];
    logic [1:0] got_codes[$];

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_sel = 2'b00; cmd_level = 1'b0; cmd_delay = '0;
    loop_en = 1'b0; rsp_b_tb = 1'b0; rsp_mb_tb = 1'b0;
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_code", evt_code, 0);
    repeat (3) step();
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_pins", {drv_a, drv_module_a}, 2'b00);
      chk("idle_ready", cmd_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_count", evt_count, 0);
    end

    // Single command, delay 5: accepted at N, pin change at N+8
    cq.push_back({2'b00, 1'b1, 8'd5});
    load_cmd();
    step();
    chk("single_accept", acc_flag, 1);
    chk("single_busy_start", busy, 1);
    repeat (7) step();
    chk("single_before", drv_a, 0);
    chk("single_busy_mid", busy, 1);
    step();
    chk("single_rise", drv_a, 1);
    chk("single_busy_end", busy, 0);
    chk("single_ma", drv_module_a, 0);

    // Six back-to-back commands delay 3: backpressure, order, 6-cycle spacing, equal-level no-op
    lv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 6; k++) cq.push_back({2'b00, lv[k], 8'd3});
    load_cmd();
    n0 = cyc + 1;
    nacc = 0;
    acc6 = -1;
    for (int t = 0; t < 40; t++) begin
      logic exp_a;
      step();
      tt = cyc - n0;
      if (acc_flag) begin
        nacc++;
        if (nacc == 6) acc6 = tt;
      end
      if (tt == 4) chk("bp_ready_full", cmd_ready, 0);
      if (tt == 6) chk("bp_ready_still_full", cmd_ready, 0);
      if (tt == 7) chk("bp_ready_after_pop", cmd_ready, 1);
      exp_a = (tt < 6) ? 1'b1 : lv[((tt - 6) / 6 > 5) ? 5 : (tt - 6) / 6];
      if (tt >= 5 && (tt % 6 == 5 || tt % 6 == 0)) chk("bp_drv_a", drv_a, exp_a);
    end
    chk("bp_sixth_accept_edge", acc6, 8);
    chk("bp_all_accepted", nacc, 6);
    chk("bp_busy_done", busy, 0);

    // Responder loopback: a up/down then module_a up/down
    loop_en = 1'b1;
    base = evt_count;
    cq.push_back({2'b00, 1'b1, 8'd0});
    cq.push_back({2'b00, 1'b0, 8'd0});
    cq.push_back({2'b01, 1'b1, 8'd0});
    cq.push_back({2'b01, 1'b0, 8'd0});
    load_cmd();
    pa = drv_a;
    pma = drv_module_a;
    for (int t = 0; t < 30; t++) begin
      step();
      if (drv_a !== pa) begin eq_code.push_back({1'b0, drv_a}); eq_time.push_back(cyc); end
      if (drv_module_a !== pma) begin eq_code.push_back({1'b1, drv_module_a}); eq_time.push_back(cyc); end
      pa = drv_a;
      pma = drv_module_a;
      if (evt_valid) begin
        got_codes.push_back(evt_code);
        if (eq_code.size() == 0) chk("loop_spurious_evt", 1, 0);
        else begin
          chk("loop_evt_code", evt_code, eq_code.pop_front());
          chk("loop_evt_latency", cyc - eq_time.pop_front(), 3);
        end
      end
    end
    chk("loop_evt_n", got_codes.size(), 4);
    if (got_codes.size() == 4) begin
      chk("loop_code0", got_codes[0], 2'b01);
      chk("loop_code1", got_codes[1], 2'b00);
      chk("loop_code2", got_codes[2], 2'b11);
      chk("loop_code3", got_codes[3], 2'b10);
    end
    chk("loop_pending_left", eq_code.size(), 0);
    chk("loop_count", evt_count, (base + 4) & 8'hff);
    loop_en = 1'b0;

    // Coincident b and module_b edges: b first, module_b next cycle
    base = evt_count;
    rsp_b_tb = 1'b1;
    rsp_mb_tb = 1'b1;
    step(); step();
    chk("coin_not_yet", evt_valid, 0);
    step();
    chk("coin_first_valid", evt_valid, 1);
    chk("coin_first_code", evt_code, 2'b01);
    step();
    chk("coin_second_valid", evt_valid, 1);
    chk("coin_second_code", evt_code, 2'b11);
    chk("coin_count", evt_count, (base + 2) & 8'hff);
    step();
    chk("coin_quiet", evt_valid, 0);
    rsp_b_tb = 1'b0;
    rsp_mb_tb = 1'b0;
    repeat (6) step();
    chk("coin_fall_count", evt_count, (base + 4) & 8'hff);

    // Reset in the middle of a long WAIT
    cq.push_back({2'b10, 1'b1, 8'd200});
    load_cmd();
    step();
    repeat (20) step();
    chk("mid_busy", busy, 1);
    chk("mid_pins", {drv_a, drv_module_a}, 2'b00);
    rst_n = 1'b0;
    cq.delete();
    cmd_valid = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ready", cmd_ready, 1);
    chk("arst_count", evt_count, 0);
    chk("arst_evt_valid", evt_valid, 0);
    repeat (2) step();
    rst_n = 1'b1;
    any_drv = 1'b0;
    for (int t = 0; t < 250; t++) begin
      step();
      any_drv = any_drv | drv_a | drv_module_a;
    end
    chk("arst_never_applied", any_drv, 0);
    chk("arst_idle_busy", busy, 0);

    // 256 events wrap the counter
    for (int i = 0; i < 255; i++) begin
      rsp_b_tb = ~rsp_b_tb;
      step(); step();
    end
    repeat (4) step();
    chk("wrap_255", evt_count, 8'd255);
    rsp_b_tb = ~rsp_b_tb;
    repeat (4) step();
    chk("wrap_zero", evt_count, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
